// File: rtl/random_pwm.sv
// random_pwm: multi-channel pseudo-random LED colour generator.
// Each channel has its own Fibonacci LFSR that supplies a random duty target.
// A shared PWM counter turns each channel's duty into a registered PWM output.
//
// Ports:
//   CLK           - system clock, rising edge
//   RSTN          - synchronous reset, active low
//   enable        - run; low freezes all state and forces pwm_out low
//   mode          - 00 jump, 01 fade, 10 freeze, 11 lamp test
//   seed_load     - reload every LFSR from seed_in (channel i gets seed_in + i)
//   seed_in       - runtime seed
//   pwm_out       - registered PWM, bit i for channel i
//   period_strobe - high during the last cycle of each PWM period
//   update_strobe - high on the period_strobe cycle that reloads the targets
module random_pwm #(
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned LFSR_WIDTH   = 16,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned HOLD_PERIODS = 256,
  parameter logic [31:0] SEED         = 32'h0000_ACE1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_in,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_strobe,
  output logic                  update_strobe
);

  typedef enum logic [1:0] {ModeJump, ModeFade, ModeFreeze, ModeLamp} mode_e;

  if (!(LFSR_WIDTH inside {32'd8, 32'd16, 32'd24, 32'd32})) begin : gen_bad_width
    $error("random_pwm: LFSR_WIDTH must be 8, 16, 24 or 32");
  end

  // Feedback tap positions as a bit mask (bit k-1 set for 1-based tap k).
  function automatic logic [LFSR_WIDTH-1:0] tap_mask();
    logic [31:0] m;
    case (LFSR_WIDTH)
      8:       m = 32'h0000_00B8;
      16:      m = 32'h0000_B400;
      24:      m = 32'h00E1_0000;
      32:      m = 32'h8020_0003;
      default: m = 32'h0000_0000;
    endcase
    return m[LFSR_WIDTH-1:0];
  endfunction

  localparam logic [LFSR_WIDTH-1:0] TapMask  = tap_mask();
  localparam logic [LFSR_WIDTH-1:0] SeedInit = SEED[LFSR_WIDTH-1:0];
  localparam logic [15:0]           HoldLast = 16'(HOLD_PERIODS - 1);

  // Per-channel seed; zero would lock the LFSR, so it is replaced by 1.
  function automatic logic [LFSR_WIDTH-1:0] chan_seed(input logic [LFSR_WIDTH-1:0] s,
                                                      input int unsigned ch);
    logic [LFSR_WIDTH-1:0] v;
    v = s + LFSR_WIDTH'(ch);
    return (v == '0) ? LFSR_WIDTH'(1) : v;
  endfunction

  logic [PWM_BITS-1:0]                    cnt_q, cnt_d;
  logic [15:0]                            hold_q, hold_d;
  logic [CHANNELS-1:0][LFSR_WIDTH-1:0]    lfsr_q, lfsr_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0]      duty_q, duty_d;
  logic [CHANNELS-1:0][PWM_BITS-1:0]      target_q, target_d;
  logic [CHANNELS-1:0]                    pwm_q, pwm_d;
  mode_e                                  mode_s;

  assign mode_s  = mode_e'(mode);
  assign pwm_out = pwm_q;

  // Strobes are combinational; gating with RSTN keeps them quiet during reset.
  always_comb begin
    period_strobe = RSTN & enable & (cnt_q == '1);
    update_strobe = period_strobe & (hold_q == HoldLast);
  end

  always_comb begin
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    lfsr_d   = lfsr_q;
    duty_d   = duty_q;
    target_d = target_q;
    pwm_d    = '0;

    if (enable) begin
      cnt_d = cnt_q + PWM_BITS'(1);
      if (period_strobe) begin
        hold_d = update_strobe ? 16'd0 : hold_q + 16'd1;
      end
      if (mode_s == ModeLamp) begin
        pwm_d = '1;
      end else begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          pwm_d[i] = (cnt_q < duty_q[i]);
        end
      end
    end

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      // Duty only moves on period boundaries so each period is glitch-free.
      if (period_strobe) begin
        case (mode_s)
          ModeJump: begin
            if (update_strobe) begin
              target_d[i] = lfsr_q[i][PWM_BITS-1:0];
              duty_d[i]   = lfsr_q[i][PWM_BITS-1:0];
            end
          end
          ModeFade: begin
            if (duty_q[i] < target_q[i]) begin
              duty_d[i] = duty_q[i] + PWM_BITS'(1);
            end else if (duty_q[i] > target_q[i]) begin
              duty_d[i] = duty_q[i] - PWM_BITS'(1);
            end
            if (update_strobe) begin
              target_d[i] = lfsr_q[i][PWM_BITS-1:0];
            end
          end
          default: ;
        endcase
      end

      // seed_load wins over stepping and works while disabled.
      if (seed_load) begin
        lfsr_d[i] = chan_seed(seed_in, i);
      end else if (enable) begin
        lfsr_d[i] = {lfsr_q[i][LFSR_WIDTH-2:0], ^(lfsr_q[i] & TapMask)};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cnt_q    <= '0;
      hold_q   <= '0;
      duty_q   <= '0;
      target_q <= '0;
      pwm_q    <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        lfsr_q[i] <= chan_seed(SeedInit, i);
      end
    end else begin
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      pwm_q    <= pwm_d;
      lfsr_q   <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_random_pwm.sv
// Self-checking bench for random_pwm (3 channels, 16-bit LFSR, 4-bit PWM, 2-period hold).
// A behavioural model tracks counter, hold, LFSR, duty and target with integer arithmetic;
// outputs are compared every cycle, and per-period high counts are compared to the duty.
module tb_random_pwm;

  localparam int N    = 3;
  localparam int P    = 4;
  localparam int H    = 2;
  localparam int SEED = 'hACE1;
  localparam int CMAX = (1 << P) - 1;

  logic         clk = 1'b0;
  logic         rstn;
  logic         en;
  logic [1:0]   mode;
  logic         sl;
  logic [15:0]  sin;
  logic [N-1:0] pwm_out;
  logic         period_strobe;
  logic         update_strobe;

  always #5 clk = ~clk;

  random_pwm #(
    .CHANNELS    (N),
    .LFSR_WIDTH  (16),
    .PWM_BITS    (P),
    .HOLD_PERIODS(H),
    .SEED        (32'h0000_ACE1)
  ) dut (
    .CLK          (clk),
    .RSTN         (rstn),
    .enable       (en),
    .mode         (mode),
    .seed_load    (sl),
    .seed_in      (sin),
    .pwm_out      (pwm_out),
    .period_strobe(period_strobe),
    .update_strobe(update_strobe)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  bit valid = 0;
  int m_cnt, m_hold, m_pwm;
  int m_lfsr[N];
  int m_duty[N];
  int m_tgt[N];

  // Per-period high-count window
  int w_acc[N];
  int w_duty[N];
  bit w_clean, w_started, prev_ps, prev_dirty;

  // Last sampled outputs
  logic [N-1:0] s_pwm;
  logic         s_ps, s_us;

  // Taps 16,14,13,11 (1-based) -> bit shifts 15,13,12,10.
  function automatic int lfsr_step(input int x);
    int fb;
    fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
    return ((x << 1) & 'hFFFF) | fb;
  endfunction

  function automatic int seed_of(input int s, input int ch);
    int v;
    v = (s + ch) % 65536;
    return (v == 0) ? 1 : v;
  endfunction

  task automatic tick();
    bit ps, us;
    int npwm;
    @(negedge clk);
    s_pwm = pwm_out;
    s_ps  = period_strobe;
    s_us  = update_strobe;
    ps = rstn && en && (m_cnt == CMAX);
    us = ps && (m_hold == H - 1);
    if (valid) begin
      check_eq("pwm_out", s_pwm, m_pwm);
      check_eq("period_strobe", s_ps, ps);
      check_eq("update_strobe", s_us, us);
      for (int c = 0; c < N; c++) w_acc[c] += int'(s_pwm[c]);
      if (prev_dirty) w_clean = 0;
      if (prev_ps) begin
        if (w_started && w_clean) begin
          for (int c = 0; c < N; c++) check_eq($sformatf("period_hi[%0d]", c), w_acc[c], w_duty[c]);
        end
        for (int c = 0; c < N; c++) begin
          w_acc[c]  = 0;
          w_duty[c] = m_duty[c];
        end
        w_clean   = 1;
        w_started = 1;
      end
    end
    prev_ps    = ps;
    prev_dirty = !rstn || (en && mode == 2'b11);

    if (!rstn) begin
      valid     = 1;
      m_cnt     = 0;
      m_hold    = 0;
      m_pwm     = 0;
      w_started = 0;
      for (int c = 0; c < N; c++) begin
        m_duty[c] = 0;
        m_tgt[c]  = 0;
        m_lfsr[c] = seed_of(SEED, c);
      end
    end else if (valid) begin
      npwm = 0;
      if (en) begin
        if (mode == 2'b11) npwm = (1 << N) - 1;
        else for (int c = 0; c < N; c++) if (m_cnt < m_duty[c]) npwm |= (1 << c);
        if (ps) begin
          for (int c = 0; c < N; c++) begin
            if (mode == 2'b00 && us) begin
              m_tgt[c]  = m_lfsr[c] & CMAX;
              m_duty[c] = m_tgt[c];
            end else if (mode == 2'b01) begin
              if (m_duty[c] < m_tgt[c]) m_duty[c]++;
              else if (m_duty[c] > m_tgt[c]) m_duty[c]--;
              if (us) m_tgt[c] = m_lfsr[c] & CMAX;
            end
          end
          m_hold = us ? 0 : m_hold + 1;
        end
        m_cnt = (m_cnt + 1) % (CMAX + 1);
      end
      for (int c = 0; c < N; c++) begin
        if (sl) m_lfsr[c] = seed_of(int'(sin), c);
        else if (en) m_lfsr[c] = lfsr_step(m_lfsr[c]);
      end
      m_pwm = npwm;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_lamp, first_ps, first_us, len, nu;
    bit found, stalled;

    // Reset with lamp test selected
    rstn = 0; en = 1; mode = 2'b11; sl = 0; sin = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i > 0) begin
        check_eq("rst_pwm", s_pwm, 0);
        check_eq("rst_ps", s_ps, 0);
        check_eq("rst_us", s_us, 0);
      end
    end
    rstn = 1;
    first_lamp = -1; first_ps = -1; first_us = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (first_lamp < 0 && s_pwm == '1) first_lamp = k;
      if (first_ps < 0 && s_ps) first_ps = k;
      if (first_us < 0 && s_us) first_us = k;
    end
    check_eq("lamp_first_cycle", first_lamp, 1);
    check_eq("first_period_strobe", first_ps, 15);
    check_eq("first_update_strobe", first_us, H * 16 - 1);

    // Jump with zero runtime seed
    mode = 2'b00; sl = 1; sin = 16'h0000;
    tick();
    sl = 0;
    repeat (320) tick();

    // Fade
    mode = 2'b01;
    repeat (400) tick();

    // Enable stall at cnt = 7
    mode = 2'b00;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (s_ps) found = 1;
    end
    check_eq("stall_sync", found, 1);
    len = 0; stalled = 0;
    for (int i = 0; i < 60; i++) begin
      if (!stalled && m_cnt == 7) begin
        en = 0;
        repeat (5) begin
          tick();
          len++;
        end
        en = 1;
        stalled = 1;
      end
      tick();
      len++;
      if (s_ps) break;
    end
    check_eq("stall_period_len", len, 21);

    // Freeze across three updates, then back to jump
    mode = 2'b10; nu = 0;
    for (int i = 0; i < 200 && nu < 3; i++) begin
      tick();
      if (s_us) nu++;
    end
    check_eq("freeze_updates", nu, 3);
    mode = 2'b00;
    repeat (100) tick();

    // Randomized mix
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) mode = 2'($urandom_range(0, 3));
      en   = ($urandom_range(0, 9) != 0);
      sl   = ($urandom_range(0, 49) == 0);
      sin  = 16'($urandom);
      rstn = ($urandom_range(0, 599) != 0);
      tick();
    end
    rstn = 1; en = 1; sl = 0; mode = 2'b01;
    repeat (64) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
